aes_key_expand_seq: RTL and testbench

Iterative AES-128 key schedule that sits directly downstream of the g-word function. It loads a 128-bit cipher key and produces round keys RK0..RK10, one per clock, for the round datapath.
Each cycle it applies RotWord, SubWord and Rcon to w3, then chains the XORs across w0..w3. The Rcon sequence comes from an internal xtime generator, so it is self-contained.

---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_key_expand_seq_g_comb.sv | 24 ++
 rtl/sbox.sv | 35 +++
 rtl/aes_key_expand_seq.sv | 106 ++++++++++
 tb/tb_aes_key_expand_seq.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key schedule: FSM encoding, Rcon constants
// and the GF(2^8) doubling used to step Rcon between rounds.
package aes_pkg;

    localparam int unsigned AES128_ROUNDS = 10;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLoad   = 2'd1;
    localparam logic [1:0] StExpand = 2'd2;

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_seq_g_comb.sv
// Combinational g-word: RotWord, SubWord and Rcon injection on the last key word.
// Kept unregistered so a full round key can be produced every cycle.
module key_g_comb (
    input  logic [31:0] word,
    input  logic [7:0]  rcon,
    output logic [31:0] g
);

    logic [31:0] rot_word;
    logic [31:0] sub_word;

    assign rot_word = {word[23:0], word[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        sbox u_sbox (
            .in_byte  (rot_word[8*i +: 8]),
            .out_byte (sub_word[8*i +: 8])
        );
    end

    // Rcon only touches the most significant byte.
    assign g = sub_word ^ {rcon, 24'h000000};

endmodule

// File: rtl/sbox.sv
// AES forward S-box, purely combinational table lookup.
module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Row r holds S(16r)..S(16r+15), entry 0 in the most significant byte.
    localparam logic [0:15][127:0] SBOX_ROWS = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [127:0] row_bits;

    // Select the row by high nibble, then the byte by low nibble (15 - col == ~col).
    always_comb begin
        row_bits = SBOX_ROWS[in_byte[7:4]];
        out_byte = row_bits[{~in_byte[3:0], 3'b000} +: 8];
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule: loads a cipher key and emits RK0..RK10,
// one round key per clock, with a self-contained Rcon generator.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] rk_out,
    output logic         rk_valid,
    output logic [3:0]   rk_index,
    output logic         busy,
    output logic         done
);

    if (NUM_ROUNDS != AES128_ROUNDS) begin : g_bad_rounds
        $error("aes_key_expand_seq: only NUM_ROUNDS == 10 is supported");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    logic [1:0]  state_q;
    logic [31:0] w0_q, w1_q, w2_q, w3_q;
    logic [7:0]  rcon_q;
    logic [3:0]  cnt_q;

    logic [31:0] g_word;
    logic [31:0] w0_d, w1_d, w2_d, w3_d;
    logic [3:0]  round_d;

    key_g_comb u_g (
        .word (w3_q),
        .rcon (rcon_q),
        .g    (g_word)
    );

    // Chained word update for the next round key.
    always_comb begin
        w0_d    = w0_q ^ g_word;
        w1_d    = w1_q ^ w0_d;
        w2_d    = w2_q ^ w1_d;
        w3_d    = w3_q ^ w2_d;
        round_d = cnt_q + 4'd1;
    end

    // FSM, key words, Rcon, round counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            w0_q     <= '0;
            w1_q     <= '0;
            w2_q     <= '0;
            w3_q     <= '0;
            rcon_q   <= RCON_INIT;
            cnt_q    <= '0;
            rk_out   <= '0;
            rk_valid <= 1'b0;
            rk_index <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    rk_valid <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    if (start) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    {w0_q, w1_q, w2_q, w3_q} <= key_in;
                    rk_out   <= key_in;
                    rk_index <= '0;
                    rk_valid <= 1'b1;
                    busy     <= 1'b1;
                    rcon_q   <= RCON_INIT;
                    cnt_q    <= '0;
                    state_q  <= StExpand;
                end
                StExpand: begin
                    w0_q     <= w0_d;
                    w1_q     <= w1_d;
                    w2_q     <= w2_d;
                    w3_q     <= w3_d;
                    rk_out   <= {w0_d, w1_d, w2_d, w3_d};
                    rk_index <= round_d;
                    rk_valid <= 1'b1;
                    rcon_q   <= xtime(rcon_q);
                    cnt_q    <= round_d;
                    if (round_d == LAST_ROUND) begin
                        done    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for the iterative AES-128 key schedule.
module tb_aes_key_expand_seq;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] rk_out;
    logic         rk_valid;
    logic [3:0]   rk_index;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1_FIPS  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK1_ZERO  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] RK10_ZERO = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic [7:0] rcon_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    // Results of the most recent single run.
    logic [127:0] cap_rk   [11];
    logic [7:0]   cap_rcon [11];
    int           cap_pulses;
    int           cap_dones;
    int           cap_done_cyc;
    int           cap_first_cyc;
    bit           cap_order_ok;
    logic         cap_busy_last;
    logic         cap_busy_after;

    aes_key_expand_seq #(.NUM_ROUNDS(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key_in   (key_in),
        .rk_out   (rk_out),
        .rk_valid (rk_valid),
        .rk_index (rk_index),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then record 14 cycles of output.
    task automatic run_capture(input logic [127:0] key);
        key_in = key;
        start  = 1'b1;
        tick();
        start = 1'b0;
        cap_pulses = 0; cap_dones = 0; cap_done_cyc = -1; cap_first_cyc = -1;
        cap_order_ok = 1'b1; cap_busy_last = 1'bx; cap_busy_after = 1'bx;
        for (int i = 0; i < 11; i++) begin
            cap_rk[i] = 'x;
            cap_rcon[i] = 'x;
        end
        for (int cyc = 1; cyc <= 14; cyc++) begin
            tick();
            if (rk_valid === 1'b1) begin
                if (cap_pulses == 0) cap_first_cyc = cyc;
                if (rk_index !== 4'(cap_pulses)) cap_order_ok = 1'b0;
                if (!$isunknown(rk_index) && rk_index <= 4'd10) begin
                    cap_rk[rk_index]   = rk_out;
                    cap_rcon[rk_index] = dut.rcon_q;
                end
                cap_pulses++;
            end
            if (done === 1'b1) begin
                cap_dones++;
                cap_done_cyc = cyc;
            end
            if (cyc == 11) cap_busy_last = busy;
            if (cyc == 12) cap_busy_after = busy;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; key_in = KEY_FIPS;
        repeat (3) tick();
        total++; if (rk_out !== '0) begin bad++; $display("FAIL reset_rk_out: got %h want 0", rk_out); end
        total++; if (rk_valid !== 1'b0) begin bad++; $display("FAIL reset_rk_valid: got %b want 0", rk_valid); end
        total++; if (rk_index !== 4'd0) begin bad++; $display("FAIL reset_rk_index: got %0d want 0", rk_index); end
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done: got %b want 00", {busy, done}); end
        total++; if (dut.rcon_q !== 8'h01) begin bad++; $display("FAIL reset_rcon: got %h want 01", dut.rcon_q); end
        total++; if (dut.state_q !== StIdle) begin bad++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, StIdle); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fips();
        run_capture(KEY_FIPS);
        total++; if (cap_pulses != 11) begin bad++; $display("FAIL fips_pulses: got %0d want 11", cap_pulses); end
        total++; if (cap_first_cyc != 1) begin bad++; $display("FAIL fips_rk0_cycle: got %0d want 1", cap_first_cyc); end
        total++; if (cap_rk[0] !== KEY_FIPS) begin bad++; $display("FAIL fips_rk0: got %h want %h", cap_rk[0], KEY_FIPS); end
        total++; if (cap_rk[1] !== RK1_FIPS) begin bad++; $display("FAIL fips_rk1: got %h want %h", cap_rk[1], RK1_FIPS); end
        total++; if (cap_rk[10] !== RK10_FIPS) begin bad++; $display("FAIL fips_rk10: got %h want %h", cap_rk[10], RK10_FIPS); end
        total++; if (cap_dones != 1) begin bad++; $display("FAIL fips_done_count: got %0d want 1", cap_dones); end
        total++; if (cap_done_cyc != 11) begin bad++; $display("FAIL fips_done_cycle: got %0d want 11", cap_done_cyc); end
        total++; if (cap_busy_last !== 1'b1) begin bad++; $display("FAIL fips_busy_rk10: got %b want 1", cap_busy_last); end
        total++; if (cap_busy_after !== 1'b0) begin bad++; $display("FAIL fips_busy_fall: got %b want 0", cap_busy_after); end
    endtask

    task automatic test_zero_key();
        run_capture('0);
        total++; if (cap_rk[0] !== '0) begin bad++; $display("FAIL zero_rk0: got %h want 0", cap_rk[0]); end
        total++; if (cap_rk[1] !== RK1_ZERO) begin bad++; $display("FAIL zero_rk1: got %h want %h", cap_rk[1], RK1_ZERO); end
        total++; if (cap_rk[10] !== RK10_ZERO) begin bad++; $display("FAIL zero_rk10: got %h want %h", cap_rk[10], RK10_ZERO); end
        total++; if (cap_pulses != 11) begin bad++; $display("FAIL zero_pulses: got %0d want 11", cap_pulses); end
    endtask

    task automatic test_rcon_index();
        run_capture(KEY_FIPS);
        // The Rcon register seen alongside RKk is the one that builds RK(k+1).
        for (int k = 0; k < 10; k++) begin
            total++;
            if (cap_rcon[k] !== rcon_exp[k]) begin
                bad++;
                $display("FAIL rcon_round%0d: got %h want %h", k + 1, cap_rcon[k], rcon_exp[k]);
            end
        end
        total++; if (cap_order_ok !== 1'b1) begin bad++; $display("FAIL index_sequence: got %b want 1", cap_order_ok); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        bit seq_ok = 1'b1;
        int second_rk0 = -1;
        logic gap_valid = 1'bx;
        logic [127:0] rk10_second = 'x;
        key_in = KEY_FIPS;
        start  = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 26; cyc++) begin
            tick();
            if (cyc == 12) begin
                gap_valid = rk_valid;
                start = 1'b0;
            end
            if (rk_valid === 1'b1) begin
                if (rk_index !== 4'(pulses % 11)) seq_ok = 1'b0;
                if (pulses == 11) second_rk0 = cyc;
                if (pulses == 21) rk10_second = rk_out;
                pulses++;
            end
        end
        total++; if (pulses != 22) begin bad++; $display("FAIL b2b_pulses: got %0d want 22", pulses); end
        total++; if (seq_ok !== 1'b1) begin bad++; $display("FAIL b2b_index_seq: got %b want 1", seq_ok); end
        total++; if (gap_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap_valid: got %b want 0", gap_valid); end
        total++; if (second_rk0 != 13) begin bad++; $display("FAIL b2b_second_rk0_cycle: got %0d want 13", second_rk0); end
        total++; if (rk10_second !== RK10_FIPS) begin bad++; $display("FAIL b2b_rk10: got %h want %h", rk10_second, RK10_FIPS); end
    endtask

    task automatic test_start_ignored();
        int pulses = 0;
        int dones = 0;
        logic [127:0] rk10 = 'x;
        key_in = KEY_FIPS;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (cyc == 5) begin
                start  = 1'b1;
                key_in = '0;
            end else begin
                start = 1'b0;
            end
            tick();
            if (rk_valid === 1'b1) begin
                if (rk_index === 4'd10) rk10 = rk_out;
                pulses++;
            end
            if (done === 1'b1) dones++;
        end
        key_in = KEY_FIPS;
        total++; if (rk10 !== RK10_FIPS) begin bad++; $display("FAIL ignore_rk10: got %h want %h", rk10, RK10_FIPS); end
        total++; if (pulses != 11) begin bad++; $display("FAIL ignore_pulses: got %0d want 11", pulses); end
        total++; if (dones != 1) begin bad++; $display("FAIL ignore_dones: got %0d want 1", dones); end
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        int pulses = 0;
        key_in = KEY_FIPS;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        total++; if (rk_out !== '0) begin bad++; $display("FAIL midrst_rk_out: got %h want 0", rk_out); end
        total++; if ({rk_valid, busy, done} !== 3'b000) begin bad++; $display("FAIL midrst_flags: got %b want 000", {rk_valid, busy, done}); end
        total++; if (rk_index !== 4'd0) begin bad++; $display("FAIL midrst_rk_index: got %0d want 0", rk_index); end
        reset = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (done === 1'b1) dones++;
            if (rk_valid === 1'b1) pulses++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL midrst_no_done: got %0d want 0", dones); end
        total++; if (pulses != 0) begin bad++; $display("FAIL midrst_no_valid: got %0d want 0", pulses); end
        run_capture(KEY_FIPS);
        total++; if (cap_rk[1] !== RK1_FIPS) begin bad++; $display("FAIL midrst_rerun_rk1: got %h want %h", cap_rk[1], RK1_FIPS); end
        total++; if (cap_rk[10] !== RK10_FIPS) begin bad++; $display("FAIL midrst_rerun_rk10: got %h want %h", cap_rk[10], RK10_FIPS); end
        total++; if (cap_dones != 1) begin bad++; $display("FAIL midrst_rerun_done: got %0d want 1", cap_dones); end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_zero_key();
        test_rcon_index();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
